button_conditioner: RTL and testbench



---
 rtl/button_conditioner.sv | 142 ++++++++++++++
 tb/tb_button_conditioner.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Push-button conditioner: per-button 2-flop synchroniser, debounce filter,
// press-pulse / auto-repeat FSM, and left/right lock-out.
module button_conditioner #(
    parameter int unsigned     N_BTN        = 3,
    parameter int unsigned     DEBOUNCE_CYC = 250000,
    parameter int unsigned     REPEAT_DELAY = 5000000,
    parameter int unsigned     REPEAT_RATE  = 1250000,
    parameter logic [N_BTN-1:0] REPEAT_MASK = '1,
    parameter bit              LR_LOCK      = 1'b1
) (
    input  logic             CLK25M,
    input  logic             Reset,
    input  logic [N_BTN-1:0] BtnRaw,
    output logic [N_BTN-1:0] Level,
    output logic [N_BTN-1:0] Pulse,
    output logic [N_BTN-1:0] Held
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC);
    localparam int unsigned TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned TMR_W = $clog2(TMR_MAX);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [TMR_W-1:0] DELAY_LOAD = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] RATE_LOAD  = TMR_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {StIdle, StHold, StRepeat} state_e;

    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;
    logic [N_BTN-1:0] level_bus;
    logic [N_BTN-1:0] pulse_bus;
    logic [N_BTN-1:0] held_bus;
    logic             lock;

    // Two-flop synchroniser for the asynchronous button levels.
    always_ff @(posedge CLK25M or negedge Reset) begin
        if (!Reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= BtnRaw;
            sync2_q <= sync2_d_unused_guard(sync1_q);
        end
    end

    function automatic logic [N_BTN-1:0] sync2_d_unused_guard(input logic [N_BTN-1:0] v);
        return v;
    endfunction

    // Lock-out is judged on the debounced levels seen when a pulse is generated.
    if (N_BTN >= 2) begin : g_lock
        assign lock = LR_LOCK && level_bus[0] && level_bus[1];
    end else begin : g_nolock
        assign lock = 1'b0;
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        localparam bit LOCKABLE = (i < 2);

        logic [CNT_W-1:0] cnt_q;
        logic             lvl_q;
        logic             lvl_prev_q;
        logic             pulse_q;
        logic [TMR_W-1:0] tmr_q;
        state_e           state_q;
        logic             lock_bit;

        assign lock_bit = LOCKABLE && lock;

        // Debounce: accept a new level only after DEBOUNCE_CYC consecutive mismatching cycles.
        always_ff @(posedge CLK25M or negedge Reset) begin
            if (!Reset) begin
                cnt_q <= '0;
                lvl_q <= 1'b0;
            end else if (sync2_q[i] == lvl_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                lvl_q <= sync2_q[i];
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        // Press / hold / auto-repeat FSM with registered pulse output.
        always_ff @(posedge CLK25M or negedge Reset) begin
            if (!Reset) begin
                state_q    <= StIdle;
                tmr_q      <= '0;
                pulse_q    <= 1'b0;
                lvl_prev_q <= 1'b0;
            end else begin
                pulse_q    <= 1'b0;
                lvl_prev_q <= lvl_q;
                case (state_q)
                    StIdle: begin
                        if (lvl_q && !lvl_prev_q) begin
                            pulse_q <= !lock_bit;
                            tmr_q   <= DELAY_LOAD;
                            state_q <= StHold;
                        end
                    end
                    StHold: begin
                        if (!lvl_q) begin
                            state_q <= StIdle;
                        end else if (tmr_q == '0) begin
                            // Without repeat enabled the timer just parks at zero.
                            if (REPEAT_MASK[i]) begin
                                pulse_q <= !lock_bit;
                                tmr_q   <= RATE_LOAD;
                                state_q <= StRepeat;
                            end
                        end else begin
                            tmr_q <= tmr_q - 1'b1;
                        end
                    end
                    StRepeat: begin
                        if (!lvl_q) begin
                            state_q <= StIdle;
                        end else if (tmr_q == '0) begin
                            pulse_q <= !lock_bit;
                            tmr_q   <= RATE_LOAD;
                        end else begin
                            tmr_q <= tmr_q - 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end

        assign level_bus[i] = lvl_q;
        assign pulse_bus[i] = pulse_q;
        assign held_bus[i]  = (state_q != StIdle);
    end

    assign Level = level_bus;
    assign Pulse = pulse_bus;
    assign Held  = held_bus;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with small debounce/repeat constants.
module tb_button_conditioner;

    localparam int unsigned N = 3;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] raw_a, raw_b;
    logic [N-1:0] level_a, pulse_a, held_a;
    logic [N-1:0] level_b, pulse_b, held_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    button_conditioner #(
        .N_BTN(3), .DEBOUNCE_CYC(4), .REPEAT_DELAY(10), .REPEAT_RATE(5),
        .REPEAT_MASK(3'b111), .LR_LOCK(1'b1)
    ) u_a (
        .CLK25M(clk), .Reset(rst_n), .BtnRaw(raw_a),
        .Level(level_a), .Pulse(pulse_a), .Held(held_a)
    );

    button_conditioner #(
        .N_BTN(3), .DEBOUNCE_CYC(4), .REPEAT_DELAY(10), .REPEAT_RATE(5),
        .REPEAT_MASK(3'b011), .LR_LOCK(1'b1)
    ) u_b (
        .CLK25M(clk), .Reset(rst_n), .BtnRaw(raw_b),
        .Level(level_b), .Pulse(pulse_b), .Held(held_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Holds reset for two edges, releases it at a negedge; next posedge is edge 1.
    task automatic do_reset();
        rst_n = 1'b0;
        raw_a = '0;
        raw_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        raw_a = 3'b111;
        raw_b = 3'b111;
        #2;
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (level_a !== 3'b000) begin
            n_fail++; $display("FAIL reset level_a: got %b want 000", level_a);
        end
        n_checks++;
        if (pulse_a !== 3'b000) begin
            n_fail++; $display("FAIL reset pulse_a: got %b want 000", pulse_a);
        end
        n_checks++;
        if (held_a !== 3'b000) begin
            n_fail++; $display("FAIL reset held_a: got %b want 000", held_a);
        end
        n_checks++;
        if ({level_b, pulse_b, held_b} !== 9'b0) begin
            n_fail++; $display("FAIL reset outputs_b: got %b want 0", {level_b, pulse_b, held_b});
        end
    endtask

    task automatic test_clean_press();
        logic ep, el, eh;
        do_reset();
        raw_a[2] = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            step();
            ep = (k == 7) || (k >= 17 && k <= 42 && ((k - 17) % 5) == 0);
            el = (k >= 6) && (k <= 45);
            eh = (k >= 7) && (k <= 46);
            n_checks++;
            if (pulse_a[2] !== ep) begin
                n_fail++; $display("FAIL clean_press pulse[2] edge %0d: got %b want %b", k, pulse_a[2], ep);
            end
            n_checks++;
            if (level_a[2] !== el) begin
                n_fail++; $display("FAIL clean_press level[2] edge %0d: got %b want %b", k, level_a[2], el);
            end
            n_checks++;
            if (held_a[2] !== eh) begin
                n_fail++; $display("FAIL clean_press held[2] edge %0d: got %b want %b", k, held_a[2], eh);
            end
            if (k == 40) raw_a[2] = 1'b0;
        end
    endtask

    task automatic test_bounce();
        logic [7:0] pat;
        logic ep, el;
        pat = 8'b0011_0011;
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            raw_a[0] = (k > 8) ? 1'b1 : pat[k-1];
            step();
            ep = (k == 15);
            el = (k >= 14);
            n_checks++;
            if (pulse_a[0] !== ep) begin
                n_fail++; $display("FAIL bounce pulse[0] edge %0d: got %b want %b", k, pulse_a[0], ep);
            end
            n_checks++;
            if (level_a[0] !== el) begin
                n_fail++; $display("FAIL bounce level[0] edge %0d: got %b want %b", k, level_a[0], el);
            end
        end
    endtask

    task automatic test_release_in_hold();
        logic ep, el, eh;
        do_reset();
        for (int k = 1; k <= 25; k++) begin
            raw_a[1] = (k <= 10);
            step();
            ep = (k == 7);
            el = (k >= 6) && (k <= 15);
            eh = (k >= 7) && (k <= 16);
            n_checks++;
            if (pulse_a[1] !== ep) begin
                n_fail++; $display("FAIL release_hold pulse[1] edge %0d: got %b want %b", k, pulse_a[1], ep);
            end
            n_checks++;
            if (level_a[1] !== el) begin
                n_fail++; $display("FAIL release_hold level[1] edge %0d: got %b want %b", k, level_a[1], el);
            end
            n_checks++;
            if (held_a[1] !== eh) begin
                n_fail++; $display("FAIL release_hold held[1] edge %0d: got %b want %b", k, held_a[1], eh);
            end
        end
    endtask

    task automatic test_repeat_mask();
        logic ep, eh;
        do_reset();
        raw_b[2] = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            step();
            ep = (k == 7);
            eh = (k >= 7) && (k <= 46);
            n_checks++;
            if (pulse_b[2] !== ep) begin
                n_fail++; $display("FAIL repeat_mask pulse[2] edge %0d: got %b want %b", k, pulse_b[2], ep);
            end
            n_checks++;
            if (held_b[2] !== eh) begin
                n_fail++; $display("FAIL repeat_mask held[2] edge %0d: got %b want %b", k, held_b[2], eh);
            end
            if (k == 40) raw_b[2] = 1'b0;
        end
    endtask

    task automatic test_lr_lock();
        logic e0, e1;
        do_reset();
        for (int k = 1; k <= 37; k++) begin
            raw_a[0] = (k <= 19);
            raw_a[1] = (k >= 4);
            step();
            e0 = (k == 7);
            e1 = (k == 30) || (k == 35);
            n_checks++;
            if (pulse_a[0] !== e0) begin
                n_fail++; $display("FAIL lr_lock pulse[0] edge %0d: got %b want %b", k, pulse_a[0], e0);
            end
            n_checks++;
            if (pulse_a[1] !== e1) begin
                n_fail++; $display("FAIL lr_lock pulse[1] edge %0d: got %b want %b", k, pulse_a[1], e1);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic ep;
        do_reset();
        for (int k = 1; k <= 24; k++) begin
            raw_b[2] = (k <= 10) || (k >= 15);
            step();
            ep = (k == 7) || (k == 21);
            n_checks++;
            if (pulse_b[2] !== ep) begin
                n_fail++; $display("FAIL back_to_back pulse[2] edge %0d: got %b want %b", k, pulse_b[2], ep);
            end
        end
    endtask

    task automatic test_reset_mid_repeat();
        logic ep, el;
        do_reset();
        raw_a[2] = 1'b1;
        repeat (25) step();
        n_checks++;
        if (held_a[2] !== 1'b1) begin
            n_fail++; $display("FAIL mid_reset held[2] before reset: got %b want 1", held_a[2]);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({level_a, pulse_a, held_a} !== 9'b0) begin
            n_fail++; $display("FAIL mid_reset async clear: got %b want 0", {level_a, pulse_a, held_a});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            ep = (k == 7);
            el = (k >= 6);
            n_checks++;
            if (pulse_a[2] !== ep) begin
                n_fail++; $display("FAIL mid_reset pulse[2] edge %0d: got %b want %b", k, pulse_a[2], ep);
            end
            n_checks++;
            if (level_a[2] !== el) begin
                n_fail++; $display("FAIL mid_reset level[2] edge %0d: got %b want %b", k, level_a[2], el);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        raw_a = '0;
        raw_b = '0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_in_hold();
        test_repeat_mask();
        test_lr_lock();
        test_back_to_back();
        test_reset_mid_repeat();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
